// File: rtl/booth_mult.sv
// booth_mult: sequential signed multiplier using radix-2 Booth recoding.
// It performs one partial-product step per clock and uses a start/busy/done handshake.
// It returns the low word of the product and flags results that do not fit in WIDTH bits.
module booth_mult #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             overflow
);

    // Accumulator width: one extra bit so that M = -2^(WIDTH-1) never wraps.
    localparam int unsigned AW = WIDTH + 1;
    // Shift register layout: {acc[AW-1:0], Q[WIDTH-1:0], q_minus1}.
    localparam int unsigned PW = 2 * WIDTH + 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        m_q, m_d;
    logic [PW-1:0]        p_q, p_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     product_q, product_d;
    logic                 overflow_q, overflow_d;
    logic                 done_q, done_d;

    logic [AW-1:0]        acc;
    logic [PW-1:0]        p_add;
    logic [PW-1:0]        p_shift;

    // Booth step: add or subtract M based on the recoded bit pair, then shift right arithmetically.
    always_comb begin
        acc = p_q[PW-1:WIDTH+1];
        case (p_q[1:0])
            2'b01:   acc = p_q[PW-1:WIDTH+1] + m_q;
            2'b10:   acc = p_q[PW-1:WIDTH+1] - m_q;
            default: acc = p_q[PW-1:WIDTH+1];
        endcase
        p_add   = {acc, p_q[WIDTH:0]};
        p_shift = {p_add[PW-1], p_add[PW-1:1]};
    end

    // Next-state logic: handle operand latch, iteration and completion.
    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = {multiplicand[WIDTH-1], multiplicand};
                    p_d     = {AW'(0), multiplier, 1'b0};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                p_d   = p_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // The full product is p_shift[2*WIDTH:1]. It fits only if the upper word is all sign bits.
                    product_d  = p_shift[WIDTH:1];
                    overflow_d = (p_shift[2*WIDTH:WIDTH+1] != {WIDTH{p_shift[WIDTH]}});
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset discards any operation in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            m_q        <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign product  = product_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_booth_mult.sv
// tb_booth_mult: self-checking bench for booth_mult.
// Results are compared against plain 64-bit signed multiplication.
module tb_booth_mult;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    booth_mult #(.WIDTH(32), .CNT_W(6)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count one comparison and report it if it does not match.
    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: bit 32 is overflow and bits 31:0 are the low product word.
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic   ovf;
        p   = longint'($signed(a)) * longint'($signed(b));
        ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        return {ovf, p[31:0]};
    endfunction

    // Start one operation at the next rising edge. Call this just after a falling edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clock);
        #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    // Sample on falling edges until done is seen. Also count the busy cycles and check that busy is low during done.
    task automatic wait_done(output int busy_cycles, output int cycles, output bit seen);
        busy_cycles = 0;
        cycles      = 0;
        seen        = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            cycles++;
            if (done) begin
                seen = 1'b1;
                check_eq("busy_low_in_done", 64'(busy), 64'd0);
                break;
            end
            if (busy) busy_cycles++;
        end
        check_eq("done_seen", 64'(seen), 64'd1);
    endtask

    // Run a full isolated operation and check latency, results and the one-cycle done pulse.
    task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b);
        int          bc;
        int          cy;
        bit          seen;
        logic [32:0] exp;
        exp = ref_mul(a, b);
        issue(a, b);
        wait_done(bc, cy, seen);
        check_eq({tag, "_busy_cycles"}, 64'(bc), 64'd32);
        check_eq({tag, "_latency"}, 64'(cy), 64'd33);
        check_eq({tag, "_product"}, 64'(product), 64'(exp[31:0]));
        check_eq({tag, "_overflow"}, 64'(overflow), 64'(exp[32]));
        @(negedge clock);
        check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
        check_eq({tag, "_hold_product"}, 64'(product), 64'(exp[31:0]));
    endtask

    initial begin
        int          bc;
        int          cy;
        bit          seen;
        bit          stray_done;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ha [3];
        logic [31:0] hb [3];
        logic [32:0] exp;
        logic [31:0] corners [6];

        corners[0] = 32'h8000_0000;
        corners[1] = 32'h7FFF_FFFF;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h0000_0000;
        corners[4] = 32'h0000_0001;
        corners[5] = 32'h0001_0000;

        reset_n      = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clock);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_product", 64'(product), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed cases.
        run_check("small", 32'd3, 32'hFFFF_FFF9);
        check_eq("small_abs", 64'(product), 64'hFFFF_FFEB);
        run_check("minneg_m1", 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("minneg_m1_abs", 64'({overflow, product}), 64'h1_8000_0000);
        run_check("minneg_p1", 32'h8000_0000, 32'd1);
        check_eq("minneg_p1_abs", 64'({overflow, product}), 64'h0_8000_0000);
        run_check("big_ovf", 32'h0001_0000, 32'h0001_0000);
        check_eq("big_ovf_abs", 64'({overflow, product}), 64'h1_0000_0000);
        run_check("zero", 32'd0, 32'd5);
        check_eq("zero_abs", 64'({overflow, product}), 64'h0_0000_0000);

        // A second start while busy must be ignored.
        issue(32'd5, 32'd6);
        repeat (9) @(negedge clock);
        issue(32'd9, 32'd9);
        wait_done(bc, cy, seen);
        check_eq("ignore_product", 64'(product), 64'd30);
        check_eq("ignore_overflow", 64'(overflow), 64'd0);
        // A start raised in the done cycle is accepted at the next edge.
        start        = 1'b1;
        multiplicand = 32'hFFFF_FFFC;
        multiplier   = 32'hFFFF_FFFC;
        @(posedge clock);
        #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        check_eq("b2b_done_drop", 64'(done), 64'd0);
        check_eq("b2b_busy_rise", 64'(busy), 64'd1);
        check_eq("b2b_hold_prev", 64'(product), 64'd30);
        wait_done(bc, cy, seen);
        check_eq("b2b_latency", 64'(cy), 64'd33);
        check_eq("b2b_product", 64'(product), 64'd16);
        @(negedge clock);

        // Randomized isolated operations, mixing in corner operands.
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = 32'($signed(16'($urandom))); b = 32'($signed(16'($urandom))); end
                2: begin a = corners[$urandom_range(0, 5)]; b = corners[$urandom_range(0, 5)]; end
                default: begin a = corners[$urandom_range(0, 5)]; b = $urandom; end
            endcase
            run_check("rand", a, b);
        end

        // Start held high: each operation is accepted in the previous done cycle. Inputs change while busy.
        for (int k = 0; k < 3; k++) begin
            ha[k] = $urandom;
            hb[k] = (k == 1) ? 32'($signed(12'($urandom))) : $urandom;
        end
        start        = 1'b1;
        multiplicand = ha[0];
        multiplier   = hb[0];
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            multiplicand = $urandom;
            multiplier   = $urandom;
            wait_done(bc, cy, seen);
            exp = ref_mul(ha[k], hb[k]);
            check_eq("held_latency", 64'(cy), 64'd33);
            check_eq("held_product", 64'(product), 64'(exp[31:0]));
            check_eq("held_overflow", 64'(overflow), 64'(exp[32]));
            if (k < 2) begin
                multiplicand = ha[k+1];
                multiplier   = hb[k+1];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clock);

        // Make the held result nonzero with overflow set, so that reset has something to clear.
        run_check("pre_rst", 32'h7FFF_FFFF, 32'h7FFF_FFFF);

        // Assert reset asynchronously in the middle of an operation.
        issue(32'd100, 32'd100);
        repeat (14) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_done", 64'(done), 64'd0);
        check_eq("arst_product", 64'(product), 64'd0);
        check_eq("arst_overflow", 64'(overflow), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        stray_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done || busy) stray_done = 1'b1;
        end
        check_eq("arst_no_done", 64'(stray_done), 64'd0);
        run_check("post_rst", 32'd2, 32'd3);
        check_eq("post_rst_abs", 64'(product), 64'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so that the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/booth_mult.md
# booth_mult

Sequential 32×32 signed multiplier using radix-2 Booth recoding, one partial-product step per clock. It is the multiply counterpart to the existing iterative divider in the ALU multiply/divide unit. Unlike the divider, it owns its iteration counter and presents a start/busy/done handshake. It returns the low 32 bits of the product plus an overflow exception.

## Interface
Parameters:
- WIDTH, 32: operand and result width. Only 32 is verified.
- CNT_W, 6: width of the internal iteration counter.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a multiply; sampled only when busy=0.
- multiplicand  in  32  signed operand M; latched on the accepting edge.
- multiplier  in  32  signed operand Q; latched on the accepting edge.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse; product and overflow are valid from this cycle on.
- product  out  32  low word of the signed 64-bit product.
- overflow  out  1  high when the 64-bit product does not fit in signed 32 bits.

## Operation
- One clock. reset_n is asynchronous and active-low.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - Unit returns to IDLE on the final iteration edge, with done=1 for that following cycle.
- IDLE, start=1 at an edge:
  - latch M into a 33-bit sign-extended register.
  - load a 66-bit shift register P = {33'b0, Q, 1'b0}.
  - count ← 0; go to RUN.
- RUN, each edge, based on P[1:0]:
  - 01: upper33 ← upper33 + M.
  - 10: upper33 ← upper33 − M.
  - 00 or 11: no add.
  - Then arithmetic-shift the whole of P right by 1 (replicating bit 65).
  - count ← count + 1.
- When count==31, the step is the last one. On that edge:
  - product ← bits [32:1] of the post-shift P.
  - overflow ← 1 iff bits [64:33] are not all equal to bit 32 of the post-shift P (full 64-bit result is P[64:1]).
  - done ← 1; go to IDLE.
- The 33-bit upper accumulator is required so that M = −2^31 never wraps.
- product and overflow hold their values until the next completion. They are not cleared by start.
- start while busy=1 is ignored; operands are not re-latched.
- Operand inputs may change freely after the accepting edge.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, busy=0, done=0, product=0, overflow=0, count=0, P=0. An in-flight operation is discarded and never produces done.
- Reset release: the first edge with reset_n=1 may accept start.
- Latency: start sampled at edge 0 → busy=1 after edge 0 → 32 RUN edges (1..32) → after edge 32, busy=0, done=1, results valid.
  - done is high exactly one cycle: the cycle after edge 32.
  - Throughput: one multiply per 33 cycles.
- Back-to-back: start=1 during the done cycle is accepted at the next edge (state is IDLE). done drops and busy rises after that edge.
- start held high continuously produces consecutive operations, each accepted in the cycle where done=1.
- busy and done are never high in the same cycle.

## Test plan
- Small signed: M=3, Q=−7 (0xFFFFFFF9) → 32 cycles later done=1, product=0xFFFFFFEB, overflow=0. Check busy high for exactly 32 cycles.
- Most-negative edge case: M=0x80000000, Q=0xFFFFFFFF → product=0x80000000, overflow=1.
- Same operand without overflow: M=0x80000000, Q=1 → product=0x80000000, overflow=0. Confirms the 33-bit accumulator does not wrap.
- Large unsigned-range overflow: M=0x00010000, Q=0x00010000 → product=0x00000000, overflow=1. Then issue M=0, Q=5 → product=0, overflow=0.
- Protocol under load:
  - pulse start with 5×6; pulse start again at cycle 10 with 9×9 → ignored; result is product=30.
  - assert start during the done cycle with −4×−4 → product=16 exactly 33 cycles after the first done.
- Reset mid-operation: start 100×100, drop reset_n asynchronously at cycle 15 (mid-cycle) → busy, done, product and overflow go to 0 immediately. No done follows. After release, 2×3 → product=6.
